// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-ported DEPTH x DATA_W memory.
// One access is serviced per clock edge; grants, errors and read returns are registered.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              busy
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = ADDR_W > 32 ? ADDR_W + 1 : 33;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              last, win0, win1, any, sel_we, in_range, pend0, pend1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, rd_q;
    logic [IW-1:0]     idx;

    // last = 1 means port 1 was granted most recently, so port 0 wins a tie
    always_comb begin
        win0      = req0 && (!req1 || last);
        win1      = req1 && (!req0 || !last);
        any       = win0 || win1;
        sel_we    = win1 ? we1 : we0;
        sel_addr  = win1 ? addr1 : addr0;
        sel_wdata = win1 ? wdata1 : wdata0;
        in_range  = CW'(sel_addr) < CW'(DEPTH);
        idx       = sel_addr[IW-1:0];
    end

    // Read data is captured at the grant edge and presented one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            busy    <= 1'b0;
            last    <= 1'b1;
            pend0   <= 1'b0;
            pend1   <= 1'b0;
            rd_q    <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            gnt0    <= win0;
            gnt1    <= win1;
            err0    <= win0 && !in_range;
            err1    <= win1 && !in_range;
            busy    <= any;
            if (any) last <= win1;
            pend0   <= win0 && !we0;
            pend1   <= win1 && !we1;
            if (any && !sel_we) rd_q <= in_range ? mem[idx] : '0;
            rvalid0 <= pend0;
            rvalid1 <= pend1;
            if (pend0) rdata0 <= rd_q;
            if (pend1) rdata1 <= rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && any && sel_we && in_range) mem[idx] <= sel_wdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios with a read-return scoreboard and a small memory model.
module tb_dmem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;

    typedef struct {int cyc; logic [31:0] d;} exp_t;
    exp_t        q0[$], q1[$];
    logic [31:0] model [16];
    int          cyc = 0, vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        check("gnt_excl", gnt0 & gnt1, 0);
        if (rvalid0) begin
            if (q0.size() == 0) check("rvalid0_spurious", rvalid0, 0);
            else begin
                e = q0.pop_front();
                check("rvalid0_cyc", cyc, e.cyc);
                check("rdata0", rdata0, e.d);
            end
        end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            check("rvalid0_missing", rvalid0, 1);
            void'(q0.pop_front());
        end
        if (rvalid1) begin
            if (q1.size() == 0) check("rvalid1_spurious", rvalid1, 0);
            else begin
                e = q1.pop_front();
                check("rvalid1_cyc", cyc, e.cyc);
                check("rdata1", rdata1, e.d);
            end
        end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            check("rvalid1_missing", rvalid1, 1);
            void'(q1.pop_front());
        end
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_gnt"}, {gnt0, gnt1, err0, err1, busy, rvalid0, rvalid1}, 0);
        check({tag, "_rdata0"}, rdata0, 0);
        check({tag, "_rdata1"}, rdata1, 0);
    endtask

    function automatic logic [31:0] mval(input logic [15:0] a);
        return a < 16 ? model[a[3:0]] : 32'h0;
    endfunction

    task automatic op(input logic r0, input logic w0, input logic [15:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [15:0] a1, input logic [31:0] d1,
                      input logic g0, input logic g1);
        exp_t e;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        tick();
        check("gnt0", gnt0, g0);
        check("gnt1", gnt1, g1);
        check("err0", err0, g0 && a0 >= 16);
        check("err1", err1, g1 && a1 >= 16);
        check("busy", busy, g0 || g1);
        if (g0) begin
            if (w0) begin
                if (a0 < 16) model[a0[3:0]] = d0;
            end else begin
                e.cyc = cyc + 1; e.d = mval(a0); q0.push_back(e);
            end
        end
        if (g1) begin
            if (w1) begin
                if (a1 < 16) model[a1[3:0]] = d1;
            end else begin
                e.cyc = cyc + 1; e.d = mval(a1); q1.push_back(e);
            end
        end
    endtask

    task automatic idle();
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tick();
        zero_check("reset");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) op(1, 1, 16'(i), 32'hA500_0000 + i, 0, 0, 0, 0, 1, 0);
        op(1, 1, 3, 32'h0000_00AA, 0, 0, 0, 0, 1, 0);
        op(1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        check("rdata0_hold", rdata0, 32'h0000_00AA);

        rst = 1'b1;
        #1;
        zero_check("rst_mid");
        tick();
        rst = 1'b0;
        op(1, 0, 1, 0, 1, 0, 2, 0, 1, 0);
        op(1, 0, 1, 0, 1, 0, 2, 0, 0, 1);
        op(1, 0, 6, 0, 1, 0, 7, 0, 1, 0);
        op(1, 0, 6, 0, 1, 0, 7, 0, 0, 1);
        idle();
        op(1, 0, 8, 0, 1, 0, 9, 0, 1, 0);
        idle();
        idle();
        op(1, 0, 8, 0, 1, 0, 9, 0, 0, 1);
        idle();

        op(1, 0, 5, 0, 1, 1, 5, 32'h1234_5678, 1, 0);
        op(0, 0, 0, 0, 1, 1, 5, 32'h1234_5678, 0, 1);
        op(1, 0, 5, 0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        check("rdata0_new", rdata0, 32'h1234_5678);

        op(1, 1, 16, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0);
        op(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 1, 0);
        op(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        op(0, 0, 0, 0, 1, 0, 17, 0, 0, 1);
        idle();
        idle();
        check("rdata0_mem0", rdata0, 32'hA500_0000);

        op(1, 0, 7, 0, 1, 1, 7, 32'hBAD0_BAD0, 1, 0);
        idle();
        op(1, 0, 7, 0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();

        op(1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        void'(q0.pop_back());
        #1;
        zero_check("rst_cancel");
        req0 = 1'b1; we0 = 1'b1; addr0 = 4; wdata0 = 32'hFFFF_FFFF;
        tick();
        zero_check("rst_hold");
        rst = 1'b0;
        op(1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        op(1, 0, 4, 0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        check("rdata0_after_rst", rdata0, 32'hA500_0004);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
